// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/avalon_arb_id_fifo.sv
// Ordered record of which master issued each outstanding read; head routes returning data.
module avalon_arb_id_fifo
  import avalon_arb_pkg::*;
#(
  parameter int MAXPENDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  master_id_t                    id_in,
  output master_id_t                    id_out,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(MAXPENDING):0]   count
);

  localparam int PW = $clog2(MAXPENDING);
  localparam int CW = PW + 1;

  master_id_t       mem [MAXPENDING];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(MAXPENDING));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign id_out  = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= id_in;
  end

endmodule

// File: rtl/avalon_arbiter_2m.sv
// Round-robin arbiter sharing one Avalon-MM slave between two masters, with pipelined read routing.
module avalon_arbiter_2m
  import avalon_arb_pkg::*;
#(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int MAXPENDING  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBADDRBITS-1:0]         m0_address,
  input  logic [NBDATABYTES-1:0]        m0_byteenable,
  input  logic                          m0_read,
  input  logic                          m0_write,
  input  logic [8*NBDATABYTES-1:0]      m0_writedata,
  output logic                          m0_waitrequest,
  output logic [8*NBDATABYTES-1:0]      m0_readdata,
  output logic                          m0_readdatavalid,
  input  logic [NBADDRBITS-1:0]         m1_address,
  input  logic [NBDATABYTES-1:0]        m1_byteenable,
  input  logic                          m1_read,
  input  logic                          m1_write,
  input  logic [8*NBDATABYTES-1:0]      m1_writedata,
  output logic                          m1_waitrequest,
  output logic [8*NBDATABYTES-1:0]      m1_readdata,
  output logic                          m1_readdatavalid,
  output logic [NBADDRBITS-1:0]         s_address,
  output logic [NBDATABYTES-1:0]        s_byteenable,
  output logic [8*NBDATABYTES-1:0]      s_writedata,
  output logic                          s_read,
  output logic                          s_write,
  input  logic                          s_waitrequest,
  input  logic [8*NBDATABYTES-1:0]      s_readdata,
  input  logic                          s_readdatavalid,
  output logic [$clog2(MAXPENDING):0]   pending_count,
  output logic                          err_unexpected_rdv
);

  arb_state_t state;
  logic       req0, req1;
  logic       blocked0, blocked1;
  logic       accept0, accept1;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  master_id_t push_id, head_id;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign blocked0 = m0_read & fifo_full;
  assign blocked1 = m1_read & fifo_full;
  assign accept0  = (state == GRANT0) & req0 & ~s_waitrequest & ~blocked0;
  assign accept1  = (state == GRANT1) & req1 & ~s_waitrequest & ~blocked1;

  assign m0_waitrequest = req0 & ~accept0;
  assign m1_waitrequest = req1 & ~accept1;

  // Grant only moves on an accept or when the holder stops requesting, so a
  // stalled transaction keeps its address/data/controls on the slave port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req0)      state <= GRANT0;
          else if (req1) state <= GRANT1;
        end
        GRANT0: if ((accept0 | ~req0) & req1) state <= GRANT1;
        GRANT1: if ((accept1 | ~req1) & req0) state <= GRANT0;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_address    = '0;
    s_byteenable = '0;
    s_writedata  = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    case (state)
      GRANT0: begin
        s_address    = m0_address;
        s_byteenable = m0_byteenable;
        s_writedata  = m0_writedata;
        s_read       = m0_read & ~blocked0;
        s_write      = m0_write;
      end
      GRANT1: begin
        s_address    = m1_address;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
        s_read       = m1_read & ~blocked1;
        s_write      = m1_write;
      end
      default: ;
    endcase
  end

  assign push    = (accept0 & m0_read) | (accept1 & m1_read);
  assign push_id = (state == GRANT1) ? M1 : M0;
  assign pop     = s_readdatavalid & ~fifo_empty;

  avalon_arb_id_fifo #(
    .MAXPENDING (MAXPENDING)
  ) u_id_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .id_in  (push_id),
    .id_out (head_id),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (pending_count)
  );

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & (head_id == M0);
  assign m1_readdatavalid = pop & (head_id == M1);

  // Data returning with nothing outstanding (e.g. issued before a reset) is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_unexpected_rdv <= 1'b0;
    else if (s_readdatavalid & fifo_empty)   err_unexpected_rdv <= 1'b1;
  end

endmodule

// File: tb/tb_avalon_arbiter_2m.sv
// Bench for avalon_arbiter_2m: directed scenarios plus randomized traffic against a queue-based model.
module tb_avalon_arbiter_2m;

  localparam int NBDATABYTES = 2;
  localparam int NBADDRBITS  = 8;
  localparam int MAXPENDING  = 4;

  logic        clk, rst;
  logic [7:0]  m0_address, m1_address, s_address;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [2:0]  pending_count;
  logic        err_unexpected_rdv;

  int tests_run    = 0;
  int tests_failed = 0;

  avalon_arbiter_2m #(
    .NBDATABYTES (NBDATABYTES),
    .NBADDRBITS  (NBADDRBITS),
    .MAXPENDING  (MAXPENDING)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .m0_address         (m0_address),
    .m0_byteenable      (m0_byteenable),
    .m0_read            (m0_read),
    .m0_write           (m0_write),
    .m0_writedata       (m0_writedata),
    .m0_waitrequest     (m0_waitrequest),
    .m0_readdata        (m0_readdata),
    .m0_readdatavalid   (m0_readdatavalid),
    .m1_address         (m1_address),
    .m1_byteenable      (m1_byteenable),
    .m1_read            (m1_read),
    .m1_write           (m1_write),
    .m1_writedata       (m1_writedata),
    .m1_waitrequest     (m1_waitrequest),
    .m1_readdata        (m1_readdata),
    .m1_readdatavalid   (m1_readdatavalid),
    .s_address          (s_address),
    .s_byteenable       (s_byteenable),
    .s_writedata        (s_writedata),
    .s_read             (s_read),
    .s_write            (s_write),
    .s_waitrequest      (s_waitrequest),
    .s_readdata         (s_readdata),
    .s_readdatavalid    (s_readdatavalid),
    .pending_count      (pending_count),
    .err_unexpected_rdv (err_unexpected_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m0_address = 8'h00; m0_byteenable = 2'b11; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 16'h0;
    m1_address = 8'h00; m1_byteenable = 2'b11; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 16'h0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    m0_read = 1'b1; m0_address = 8'h5A;
    @(negedge clk);
    tests_run++; if (pending_count !== 3'd0) begin tests_failed++; $display("FAIL reset_pending got %0d expected 0", pending_count); end
    tests_run++; if (err_unexpected_rdv !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b expected 0", err_unexpected_rdv); end
    tests_run++; if (s_read !== 1'b0 || s_write !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ctrl got rd=%b wr=%b expected 0/0", s_read, s_write); end
    tests_run++; if (s_address !== 8'h00) begin tests_failed++; $display("FAIL reset_s_address got %h expected 00", s_address); end
    tests_run++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0) begin tests_failed++; $display("FAIL reset_wait got m0=%b m1=%b expected 1/0", m0_waitrequest, m1_waitrequest); end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int wr_cycles = 0;
    int wait_cycles = 0;
    do_reset();
    m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 16'hBEEF; s_waitrequest = 1'b1;
    @(negedge clk);
    tests_run++; if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL sw_idle got s_write=%b wait=%b expected 0/1", s_write, m0_waitrequest); end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      s_waitrequest = (c < 3);
      @(negedge clk);
      if (s_write === 1'b1) wr_cycles++;
      if (m0_waitrequest === 1'b1) wait_cycles++;
      tests_run++; if (s_address !== 8'h10 || s_writedata !== 16'hBEEF) begin tests_failed++; $display("FAIL sw_stable cyc %0d got %h/%h expected 10/beef", c, s_address, s_writedata); end
    end
    tests_run++; if (wr_cycles != 3) begin tests_failed++; $display("FAIL sw_write_cycles got %0d expected 3", wr_cycles); end
    tests_run++; if (wait_cycles != 2) begin tests_failed++; $display("FAIL sw_wait_cycles got %0d expected 2", wait_cycles); end
    @(posedge clk); #1;
    m0_write = 1'b0; s_waitrequest = 1'b0;
    @(posedge clk); #1;
    m0_write = 1'b1; m0_address = 8'h20; m0_writedata = 16'h1234;
    @(negedge clk);
    tests_run++; if (s_write !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 8'h20) begin tests_failed++; $display("FAIL sw_parked got s_write=%b wait=%b addr=%h expected 1/0/20", s_write, m0_waitrequest, s_address); end
    @(posedge clk); #1;
    m0_write = 1'b0;
  endtask

  task automatic test_contention();
    logic [7:0] a0, a1;
    do_reset();
    m0_read = 1'b1; m0_address = 8'h01;
    m1_read = 1'b1; m1_address = 8'h02;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ct_idle got s_read=%b w0=%b w1=%b expected 0/1/1", s_read, m0_waitrequest, m1_waitrequest); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b1 || s_address !== 8'h01 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ct_first got rd=%b addr=%h w0=%b w1=%b expected 1/01/0/1", s_read, s_address, m0_waitrequest, m1_waitrequest); end
    @(posedge clk); #1;
    a0 = 8'h40; a1 = 8'h80;
    m0_read = 1'b0; m0_write = 1'b1; m0_address = a0;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b1 || s_address !== 8'h02 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ct_second got rd=%b addr=%h w1=%b w0=%b expected 1/02/0/1", s_read, s_address, m1_waitrequest, m0_waitrequest); end
    @(posedge clk); #1;
    m1_read = 1'b0; m1_write = 1'b1; m1_address = a1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        tests_run++; if (s_write !== 1'b1 || s_address !== a0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ct_alt k=%0d got addr=%h w0=%b w1=%b expected %h/0/1", k, s_address, m0_waitrequest, m1_waitrequest, a0); end
        a0 = a0 + 8'd1;
      end else begin
        tests_run++; if (s_write !== 1'b1 || s_address !== a1 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ct_alt k=%0d got addr=%h w1=%b w0=%b expected %h/0/1", k, s_address, m1_waitrequest, m0_waitrequest, a1); end
        a1 = a1 + 8'd1;
      end
      @(posedge clk); #1;
      m0_address = a0; m1_address = a1;
    end
    m0_write = 1'b0; m1_write = 1'b0;
    @(negedge clk);
    tests_run++; if (pending_count !== 3'd2) begin tests_failed++; $display("FAIL ct_pending got %0d expected 2", pending_count); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b1; s_readdata = 16'h1111;
    @(negedge clk);
    tests_run++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL ct_rdv0 got %b/%b expected 1/0", m0_readdatavalid, m1_readdatavalid); end
    @(posedge clk); #1;
    s_readdata = 16'h2222;
    @(negedge clk);
    tests_run++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b1 || m1_readdata !== 16'h2222) begin tests_failed++; $display("FAIL ct_rdv1 got %b/%b data %h expected 0/1 2222", m0_readdatavalid, m1_readdatavalid, m1_readdata); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_pipelined();
    int pend_exp [7] = '{0, 0, 1, 2, 2, 1, 0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin m0_read = 1'b1; m0_address = 8'h01; m1_read = 1'b1; m1_address = 8'h02; end
        2: m0_read = 1'b0;
        3: m1_read = 1'b0;
        4: begin s_readdatavalid = 1'b1; s_readdata = 16'hAAAA; end
        5: s_readdata = 16'hBBBB;
        6: s_readdatavalid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      tests_run++; if (pending_count !== 3'(pend_exp[c])) begin tests_failed++; $display("FAIL pl_pending cyc %0d got %0d expected %0d", c, pending_count, pend_exp[c]); end
      if (c == 4) begin
        tests_run++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 16'hAAAA) begin tests_failed++; $display("FAIL pl_m0 got %b/%b data %h expected 1/0 aaaa", m0_readdatavalid, m1_readdatavalid, m0_readdata); end
      end
      if (c == 5) begin
        tests_run++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 16'hBBBB) begin tests_failed++; $display("FAIL pl_m1 got %b/%b data %h expected 1/0 bbbb", m1_readdatavalid, m0_readdatavalid, m1_readdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_fifo();
    do_reset();
    m0_read = 1'b1; m0_address = 8'h30;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin m1_write = 1'b1; m1_address = 8'h99; m1_writedata = 16'h1234; end
      @(negedge clk);
      if (c == 4) begin
        tests_run++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || pending_count !== 3'd3) begin tests_failed++; $display("FAIL ff_fourth got w0=%b w1=%b pend=%0d expected 0/1/3", m0_waitrequest, m1_waitrequest, pending_count); end
      end
      @(posedge clk); #1;
    end
    m0_address = 8'h35;
    @(negedge clk);
    tests_run++; if (s_write !== 1'b1 || s_address !== 8'h99 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || pending_count !== 3'd4) begin tests_failed++; $display("FAIL ff_write got wr=%b addr=%h w1=%b w0=%b pend=%0d expected 1/99/0/1/4", s_write, s_address, m1_waitrequest, m0_waitrequest, pending_count); end
    @(posedge clk); #1;
    m1_write = 1'b0;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL ff_blocked got rd=%b w0=%b expected 0/1", s_read, m0_waitrequest); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b1; s_readdata = 16'hC0DE;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b1) begin tests_failed++; $display("FAIL ff_pop_same got rd=%b w0=%b rdv=%b expected 0/1/1", s_read, m0_waitrequest, m0_readdatavalid); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
    @(negedge clk);
    tests_run++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 8'h35 || pending_count !== 3'd3) begin tests_failed++; $display("FAIL ff_after got rd=%b w0=%b addr=%h pend=%0d expected 1/0/35/3", s_read, m0_waitrequest, s_address, pending_count); end
    @(posedge clk); #1;
    m0_read = 1'b0;
    @(negedge clk);
    tests_run++; if (pending_count !== 3'd4) begin tests_failed++; $display("FAIL ff_refill got %0d expected 4", pending_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_stray();
    do_reset();
    s_readdatavalid = 1'b1; s_readdata = 16'h5555;
    @(negedge clk);
    tests_run++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL st_rdv got %b/%b expected 0/0", m0_readdatavalid, m1_readdatavalid); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
    @(negedge clk);
    tests_run++; if (err_unexpected_rdv !== 1'b1) begin tests_failed++; $display("FAIL st_err_set got %b expected 1", err_unexpected_rdv); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++; if (err_unexpected_rdv !== 1'b1) begin tests_failed++; $display("FAIL st_err_sticky got %b expected 1", err_unexpected_rdv); end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    tests_run++; if (err_unexpected_rdv !== 1'b0) begin tests_failed++; $display("FAIL st_err_clear got %b expected 0", err_unexpected_rdv); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_read = 1'b1; m0_address = 8'h77;
    repeat (3) begin @(posedge clk); #1; end
    m0_read = 1'b0;
    @(negedge clk);
    tests_run++; if (pending_count !== 3'd2 || s_address !== 8'h77) begin tests_failed++; $display("FAIL rm_before got pend=%0d addr=%h expected 2/77", pending_count, s_address); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests_run++; if (pending_count !== 3'd0 || s_address !== 8'h00) begin tests_failed++; $display("FAIL rm_async got pend=%0d addr=%h expected 0/00", pending_count, s_address); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (s_address !== 8'h00 || s_read !== 1'b0) begin tests_failed++; $display("FAIL rm_idle got addr=%h rd=%b expected 00/0", s_address, s_read); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
    @(negedge clk);
    tests_run++; if (m0_readdatavalid !== 1'b0) begin tests_failed++; $display("FAIL rm_dropped got %b expected 0", m0_readdatavalid); end
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
    @(negedge clk);
    tests_run++; if (err_unexpected_rdv !== 1'b1) begin tests_failed++; $display("FAIL rm_err got %b expected 1", err_unexpected_rdv); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          owner;
    int          q[$];
    bit          merr;
    int          slave_cnt;
    bit [1:0]    act, isrd, rd, wr, rq, bl, ac;
    bit          full, e_sread, e_swrite, e_rdv0, e_rdv1;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;
    logic [1:0]  e_be;
    int          e_pend;
    do_reset();
    owner = -1; q.delete(); merr = 1'b0; slave_cnt = 0; act = '0; isrd = '0;
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && ($urandom % 3 != 0)) begin
          act[n]  = 1'b1;
          isrd[n] = 1'($urandom);
          if (n == 0) begin m0_address = 8'($urandom); m0_writedata = 16'($urandom); m0_byteenable = 2'($urandom); end
          else        begin m1_address = 8'($urandom); m1_writedata = 16'($urandom); m1_byteenable = 2'($urandom); end
        end
      end
      m0_read = act[0] & isrd[0]; m0_write = act[0] & ~isrd[0];
      m1_read = act[1] & isrd[1]; m1_write = act[1] & ~isrd[1];
      s_waitrequest   = ($urandom % 4 == 0);
      s_readdatavalid = (slave_cnt > 0) && ($urandom % 3 == 0);
      s_readdata      = 16'($urandom);
      @(negedge clk);
      rd = {m1_read, m0_read}; wr = {m1_write, m0_write};
      full = (q.size() == MAXPENDING);
      for (int n = 0; n < 2; n++) begin
        rq[n] = rd[n] | wr[n];
        bl[n] = rd[n] & full;
        ac[n] = (owner == n) && rq[n] && !s_waitrequest && !bl[n];
      end
      e_sread  = (owner >= 0) ? (rd[owner] & ~bl[owner]) : 1'b0;
      e_swrite = (owner >= 0) ? wr[owner] : 1'b0;
      e_addr   = (owner == 0) ? m0_address    : (owner == 1) ? m1_address    : 8'h00;
      e_wd     = (owner == 0) ? m0_writedata  : (owner == 1) ? m1_writedata  : 16'h0;
      e_be     = (owner == 0) ? m0_byteenable : (owner == 1) ? m1_byteenable : 2'b00;
      e_rdv0   = s_readdatavalid && q.size() > 0 && q[0] == 0;
      e_rdv1   = s_readdatavalid && q.size() > 0 && q[0] == 1;
      e_pend   = q.size();
      tests_run++; if (s_read !== e_sread) begin tests_failed++; $display("FAIL rnd_s_read cyc %0d got %b expected %b", i, s_read, e_sread); end
      tests_run++; if (s_write !== e_swrite) begin tests_failed++; $display("FAIL rnd_s_write cyc %0d got %b expected %b", i, s_write, e_swrite); end
      tests_run++; if (s_address !== e_addr || s_writedata !== e_wd || s_byteenable !== e_be) begin tests_failed++; $display("FAIL rnd_s_bus cyc %0d got %h/%h/%b expected %h/%h/%b", i, s_address, s_writedata, s_byteenable, e_addr, e_wd, e_be); end
      tests_run++; if (m0_waitrequest !== (rq[0] & ~ac[0]) || m1_waitrequest !== (rq[1] & ~ac[1])) begin tests_failed++; $display("FAIL rnd_wait cyc %0d got %b/%b expected %b/%b", i, m0_waitrequest, m1_waitrequest, rq[0] & ~ac[0], rq[1] & ~ac[1]); end
      tests_run++; if (m0_readdatavalid !== e_rdv0 || m1_readdatavalid !== e_rdv1) begin tests_failed++; $display("FAIL rnd_rdv cyc %0d got %b/%b expected %b/%b", i, m0_readdatavalid, m1_readdatavalid, e_rdv0, e_rdv1); end
      tests_run++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin tests_failed++; $display("FAIL rnd_rdata cyc %0d got %h/%h expected %h", i, m0_readdata, m1_readdata, s_readdata); end
      tests_run++; if (pending_count !== 3'(e_pend)) begin tests_failed++; $display("FAIL rnd_pending cyc %0d got %0d expected %0d", i, pending_count, e_pend); end
      tests_run++; if (err_unexpected_rdv !== merr) begin tests_failed++; $display("FAIL rnd_err cyc %0d got %b expected %b", i, err_unexpected_rdv, merr); end
      if (s_readdatavalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1'b1;
        slave_cnt--;
      end
      if (e_sread && !s_waitrequest) slave_cnt++;
      for (int n = 0; n < 2; n++) begin
        if (ac[n] && rd[n]) q.push_back(n);
        if (ac[n]) act[n] = 1'b0;
      end
      if (owner < 0) begin
        owner = rq[0] ? 0 : (rq[1] ? 1 : -1);
      end else if ((ac[owner] || !rq[owner]) && rq[1-owner]) begin
        owner = 1 - owner;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_single_write();
    test_contention();
    test_pipelined();
    test_full_fifo();
    test_stray();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
